// File: rtl/name_issue_arbiter.sv
// name_issue_arbiter: shares the FIB pipeline name-component input between two
// requesters. Round-robin grant per name, one component per cycle with
// first/last/src/index tags, honours pipe_stall, truncates names longer than
// MAX_NAME_LENGTH by draining the surplus components.
// Optional feature: define NAME_ARB_STATS_EN to build the saturating statistics
// counters; otherwise the stat_* ports are tied to zero.
module name_issue_arbiter #(
  parameter int WORD_SIZE         = 32,
  parameter int MAX_NAME_LENGTH   = 8,
  parameter int STRIDE_INDEX_SIZE = 3,
  parameter int STATS_WIDTH       = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         req_valid_1,
  input  logic [WORD_SIZE-1:0]         req_word_1,
  input  logic                         req_last_1,
  output logic                         req_ready_1,
  input  logic                         req_valid_2,
  input  logic [WORD_SIZE-1:0]         req_word_2,
  input  logic                         req_last_2,
  output logic                         req_ready_2,
  input  logic                         pipe_stall,
  output logic                         pipe_valid,
  output logic [WORD_SIZE-1:0]         pipe_word,
  output logic                         pipe_first,
  output logic                         pipe_last,
  output logic                         pipe_src,
  output logic [STRIDE_INDEX_SIZE-1:0] pipe_index,
  output logic                         trunc_err,
  output logic                         busy,
  output logic [STATS_WIDTH-1:0]       stat_names_1,
  output logic [STATS_WIDTH-1:0]       stat_names_2,
  output logic [STATS_WIDTH-1:0]       stat_trunc
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam logic [STRIDE_INDEX_SIZE-1:0] LAST_IDX =
    STRIDE_INDEX_SIZE'(MAX_NAME_LENGTH - 1);

  logic [1:0]                   r_state;
  logic                         r_owner;   // 0 = requester 1, 1 = requester 2
  logic                         r_rr;      // requester favoured on contention
  logic [STRIDE_INDEX_SIZE-1:0] r_count;

  logic                         r_vld_p1;
  logic [WORD_SIZE-1:0]         r_word_p1;
  logic                         r_first_p1;
  logic                         r_last_p1;
  logic                         r_src_p1;
  logic [STRIDE_INDEX_SIZE-1:0] r_index_p1;
  logic                         r_trunc_p1;

  logic                 w_own_valid;
  logic [WORD_SIZE-1:0] w_own_word;
  logic                 w_own_last;
  logic                 w_own_ready;
  logic                 w_xfer;
  logic                 w_issue;
  logic                 w_at_max;
  logic                 w_issue_last;
  logic                 w_trunc;
  logic                 w_name_end;
  logic                 w_any_req;
  logic                 w_grant_src;

  // The non-owner is never ready, so its valid is ignored while a name is open.
  assign w_own_valid  = r_owner ? req_valid_2 : req_valid_1;
  assign w_own_word   = r_owner ? req_word_2  : req_word_1;
  assign w_own_last   = r_owner ? req_last_2  : req_last_1;
  // DRAIN swallows surplus components even while the pipeline is stalled.
  assign w_own_ready  = ((r_state == ST_STREAM) && !pipe_stall) || (r_state == ST_DRAIN);
  assign req_ready_1  = w_own_ready && !r_owner;
  assign req_ready_2  = w_own_ready && r_owner;

  assign w_xfer       = w_own_valid && w_own_ready;
  assign w_issue      = w_xfer && (r_state == ST_STREAM);
  assign w_at_max     = (r_count == LAST_IDX);
  assign w_issue_last = w_own_last || w_at_max;
  assign w_trunc      = w_issue && w_at_max && !w_own_last;
  assign w_name_end   = w_xfer && w_own_last;

  assign w_any_req    = req_valid_1 || req_valid_2;
  assign w_grant_src  = (req_valid_1 && req_valid_2) ? r_rr : req_valid_2;

  assign busy = (r_state != ST_IDLE);

  // Name-level control: grant, component counting, truncation and round-robin.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_STREAM;
            r_owner <= w_grant_src;
            r_count <= '0;
          end
        end
        ST_STREAM: begin
          if (w_issue) begin
            if (w_own_last) begin
              r_state <= ST_IDLE;
              r_rr    <= ~r_owner;
              r_count <= '0;
            end else if (w_at_max) begin
              r_state <= ST_DRAIN;
              r_count <= '0;
            end else begin
              r_count <= r_count + STRIDE_INDEX_SIZE'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_name_end) begin
            r_state <= ST_IDLE;
            r_rr    <= ~r_owner;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p1: issued component register, held while the pipeline stalls ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld_p1   <= 1'b0;
      r_word_p1  <= '0;
      r_first_p1 <= 1'b0;
      r_last_p1  <= 1'b0;
      r_src_p1   <= 1'b0;
      r_index_p1 <= '0;
      r_trunc_p1 <= 1'b0;
    end else begin
      r_trunc_p1 <= w_trunc;
      if (w_issue) begin
        r_vld_p1   <= 1'b1;
        r_word_p1  <= w_own_word;
        r_first_p1 <= (r_count == '0);
        r_last_p1  <= w_issue_last;
        r_src_p1   <= r_owner;
        r_index_p1 <= r_count;
      end else if (!pipe_stall) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign pipe_valid = r_vld_p1;
  assign pipe_word  = r_word_p1;
  assign pipe_first = r_first_p1;
  assign pipe_last  = r_last_p1;
  assign pipe_src   = r_src_p1;
  assign pipe_index = r_index_p1;
  assign trunc_err  = r_trunc_p1;

`ifdef NAME_ARB_STATS_EN
  function automatic logic [STATS_WIDTH-1:0] f_sat_inc(input logic [STATS_WIDTH-1:0] v);
    return (&v) ? v : v + STATS_WIDTH'(1);
  endfunction

  logic [STATS_WIDTH-1:0] r_stat_n1;
  logic [STATS_WIDTH-1:0] r_stat_n2;
  logic [STATS_WIDTH-1:0] r_stat_tr;

  // Saturating counts of names completed per source and of truncated names.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_stat_n1 <= '0;
      r_stat_n2 <= '0;
      r_stat_tr <= '0;
    end else begin
      if (w_issue && w_issue_last && !r_owner) r_stat_n1 <= f_sat_inc(r_stat_n1);
      if (w_issue && w_issue_last && r_owner)  r_stat_n2 <= f_sat_inc(r_stat_n2);
      if (w_trunc)                             r_stat_tr <= f_sat_inc(r_stat_tr);
    end
  end

  assign stat_names_1 = r_stat_n1;
  assign stat_names_2 = r_stat_n2;
  assign stat_trunc   = r_stat_tr;
`else
  assign stat_names_1 = '0;
  assign stat_names_2 = '0;
  assign stat_trunc   = '0;
`endif

endmodule

// File: tb/tb_name_issue_arbiter.sv
// Randomized bench for name_issue_arbiter: two requesters stream names of random
// length with random gaps and bubbles against a random pipeline stall; a
// name-level reference model predicts ready, issued components and statistics.
module tb_name_issue_arbiter;
  localparam int WS   = 32;
  localparam int MAXL = 8;
  localparam int IW   = 3;
  localparam int SW   = 16;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          req_valid_1, req_last_1, req_ready_1;
  logic [WS-1:0] req_word_1;
  logic          req_valid_2, req_last_2, req_ready_2;
  logic [WS-1:0] req_word_2;
  logic          pipe_stall;
  logic          pipe_valid, pipe_first, pipe_last, pipe_src, trunc_err, busy;
  logic [WS-1:0] pipe_word;
  logic [IW-1:0] pipe_index;
  logic [SW-1:0] stat_names_1, stat_names_2, stat_trunc;

  always #5 clk_in = ~clk_in;

  name_issue_arbiter #(
    .WORD_SIZE(WS), .MAX_NAME_LENGTH(MAXL), .STRIDE_INDEX_SIZE(IW), .STATS_WIDTH(SW)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_1(req_valid_1), .req_word_1(req_word_1), .req_last_1(req_last_1),
    .req_ready_1(req_ready_1),
    .req_valid_2(req_valid_2), .req_word_2(req_word_2), .req_last_2(req_last_2),
    .req_ready_2(req_ready_2),
    .pipe_stall(pipe_stall), .pipe_valid(pipe_valid), .pipe_word(pipe_word),
    .pipe_first(pipe_first), .pipe_last(pipe_last), .pipe_src(pipe_src),
    .pipe_index(pipe_index), .trunc_err(trunc_err), .busy(busy),
    .stat_names_1(stat_names_1), .stat_names_2(stat_names_2), .stat_trunc(stat_trunc)
  );

  // requester drive state
  logic          d_valid [2];
  logic [WS-1:0] d_word  [2];
  logic          d_last  [2];
  int            s_pos [2];
  int            s_len [2];
  int            s_id  [2];
  int            s_gap [2];

  assign req_valid_1 = d_valid[0];
  assign req_word_1  = d_word[0];
  assign req_last_1  = d_last[0];
  assign req_valid_2 = d_valid[1];
  assign req_word_2  = d_word[1];
  assign req_last_2  = d_last[1];

  // reference model: a name is open for one owner; m_pos counts components
  // accepted in the open name, those at or beyond MAXL are discarded
  bit            m_active;
  int            m_owner;
  int            m_pos;
  int            m_favour;
  logic          e_vld, e_first, e_last, e_src, e_trunc;
  logic [WS-1:0] e_word;
  int            e_idx;
  int            e_n1, e_n2, e_tr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WS-1:0] mk_word(input int r, input int id, input int pos);
    return {4'(r + 1), 12'(id), 16'(pos)};
  endfunction

  function automatic bit m_ready(input int r);
    return m_active && (m_owner == r) && ((m_pos >= MAXL) || !pipe_stall);
  endfunction

  task automatic m_reset();
    m_active = 0; m_owner = 0; m_pos = 0; m_favour = 0;
    e_vld = 0; e_first = 0; e_last = 0; e_src = 0; e_trunc = 0; e_word = '0; e_idx = 0;
    e_n1 = 0; e_n2 = 0; e_tr = 0;
  endtask

  task automatic new_name(input int r);
    s_pos[r] = 0;
    s_len[r] = $urandom_range(1, 11);
    s_id[r]  = s_id[r] + 1;
  endtask

  task automatic chk_outputs();
    chk("pipe_valid", 64'(pipe_valid), 64'(e_vld));
    if (e_vld) begin
      chk("pipe_word",  64'(pipe_word),  64'(e_word));
      chk("pipe_first", 64'(pipe_first), 64'(e_first));
      chk("pipe_last",  64'(pipe_last),  64'(e_last));
      chk("pipe_src",   64'(pipe_src),   64'(e_src));
      chk("pipe_index", 64'(pipe_index), 64'(e_idx));
    end
    chk("trunc_err", 64'(trunc_err), 64'(e_trunc));
    chk("busy",      64'(busy),      64'(m_active));
`ifdef NAME_ARB_STATS_EN
    chk("stat_names_1", 64'(stat_names_1), 64'(e_n1));
    chk("stat_names_2", 64'(stat_names_2), 64'(e_n2));
    chk("stat_trunc",   64'(stat_trunc),   64'(e_tr));
`else
    chk("stat_names_1", 64'(stat_names_1), 64'(0));
    chk("stat_names_2", 64'(stat_names_2), 64'(0));
    chk("stat_trunc",   64'(stat_trunc),   64'(0));
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(pipe_valid), 64'(0));
    chk({tag, "_word"},  64'(pipe_word),  64'(0));
    chk({tag, "_flags"}, 64'({pipe_first, pipe_last, pipe_src, trunc_err, busy}), 64'(0));
    chk({tag, "_index"}, 64'(pipe_index), 64'(0));
    chk({tag, "_ready"}, 64'({req_ready_1, req_ready_2}), 64'(0));
    chk({tag, "_stats"}, 64'({stat_names_1, stat_names_2, stat_trunc}), 64'(0));
  endtask

  task automatic do_cycle(input int stall_pct, input int bub_pct);
    bit xr [2];
    bit ld;
    int o;
    @(negedge clk_in);
    chk_outputs();
    pipe_stall = ($urandom_range(0, 99) < stall_pct);
    for (int r = 0; r < 2; r++) begin
      if (s_gap[r] > 0) begin
        d_valid[r] = 1'b0;
        s_gap[r]   = s_gap[r] - 1;
      end else begin
        d_valid[r] = ($urandom_range(0, 99) >= bub_pct);
      end
      d_word[r] = mk_word(r, s_id[r], s_pos[r]);
      d_last[r] = (s_pos[r] == s_len[r] - 1);
    end
    #1;
    chk("req_ready_1", 64'(req_ready_1), 64'(m_ready(0)));
    chk("req_ready_2", 64'(req_ready_2), 64'(m_ready(1)));
    for (int r = 0; r < 2; r++) xr[r] = d_valid[r] && m_ready(r);
    @(posedge clk_in);
    ld      = 0;
    e_trunc = 1'b0;
    if (m_active && xr[m_owner]) begin
      o = m_owner;
      if (m_pos < MAXL) begin
        ld      = 1;
        e_vld   = 1'b1;
        e_word  = d_word[o];
        e_src   = 1'(o);
        e_idx   = m_pos;
        e_first = (m_pos == 0);
        e_last  = d_last[o] || (m_pos == MAXL - 1);
        e_trunc = (m_pos == MAXL - 1) && !d_last[o];
        if (e_last) begin
          if (o == 0) e_n1++; else e_n2++;
        end
        if (e_trunc) e_tr++;
      end
      if (d_last[o]) begin
        m_active = 0;
        m_favour = 1 - o;
      end else begin
        m_pos++;
      end
    end else if (!m_active && (d_valid[0] || d_valid[1])) begin
      m_active = 1;
      m_owner  = (d_valid[0] && d_valid[1]) ? m_favour : (d_valid[0] ? 0 : 1);
      m_pos    = 0;
    end
    if (!ld && !pipe_stall) e_vld = 1'b0;
    for (int r = 0; r < 2; r++) begin
      if (xr[r]) begin
        if (d_last[r]) begin
          new_name(r);
          s_gap[r] = $urandom_range(0, 3);
        end else begin
          s_pos[r] = s_pos[r] + 1;
        end
      end
    end
  endtask

  initial begin
    bit hit;
    rst_n_in   = 1'b0;
    pipe_stall = 1'b0;
    for (int r = 0; r < 2; r++) begin
      d_valid[r] = 1'b0; d_word[r] = '0; d_last[r] = 1'b0;
      s_id[r] = 0; s_gap[r] = 0;
      new_name(r);
    end
    m_reset();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_all_zero("reset");
    rst_n_in = 1'b1;

    repeat (800) do_cycle(0, 0);
    repeat (800) do_cycle(30, 10);
    repeat (800) do_cycle(10, 40);

    // asynchronous reset in the middle of a name, at component index 4
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      do_cycle(10, 10);
      hit = m_active && (m_pos == 4);
    end
    chk("reset_point_found", 64'(hit), 64'(1));
    @(negedge clk_in);
    chk_outputs();
    #2 rst_n_in = 1'b0;
    #1 chk_all_zero("async_reset");
    for (int r = 0; r < 2; r++) begin
      d_valid[r] = 1'b0;
      new_name(r);
      s_gap[r] = 0;
    end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk_all_zero("reset_hold");
    m_reset();
    rst_n_in = 1'b1;

    repeat (800) do_cycle(20, 20);
    repeat (400) do_cycle(60, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
